// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the program/data RAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Ownership states of the shared RAM port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Requester identities, also used as the read-return tag.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_HOST  = 1'b1;

    localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/mem_port_arbiter_burst_counter.sv
// Counts consecutive accesses of the current RAM owner; flags the last allowed one.
// Latency: o_last reflects the registered count (valid the same cycle as the access).
// Backpressure: none; i_clr has priority over i_inc, count saturates at MAX_BURST-1.
// Ports: clk/rst, i_clr (state change), i_inc (owner stays and accesses), o_last.
module mem_port_arbiter_burst_counter #(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LAST_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last = (r_cnt == LAST_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-ported program/data RAM (fetch vs host loader).
// Latency: grant 1 cycle after request in IDLE; read data/rvalid 1 cycle after the access.
// Backpressure: a requester holds req until granted; owner is forced off after MAX_BURST under contention.
// Ports: req/addr/wdata/we per requester in, gnt/rvalid per requester out,
//        shared rdata out, mem_* RAM strobe/address/data out, mem_rdata in.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_owner;
    logic       r_rd_pend;
    logic       r_rd_tag;
    logic       w_inc;
    logic       w_clr;
    logic       w_last;
    logic       w_fire0;
    logic       w_fire1;

    mem_port_arbiter_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Tie goes to whoever did not own the port most recently.
                if (req0 && req1) begin
                    w_state_nxt = (r_last_owner == REQ_HOST) ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    w_state_nxt = ST_OWN0;
                end else if (req1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    w_state_nxt = req1 ? ST_OWN1 : ST_IDLE;
                end else if (req1 && w_last) begin
                    w_state_nxt = ST_OWN1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    w_state_nxt = req0 ? ST_OWN0 : ST_IDLE;
                end else if (req0 && w_last) begin
                    w_state_nxt = ST_OWN0;
                end else begin
                    w_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_clr = (w_state_nxt != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= REQ_HOST;
        end else if (w_clr && (w_state_nxt == ST_OWN0)) begin
            r_last_owner <= REQ_FETCH;
        end else if (w_clr && (w_state_nxt == ST_OWN1)) begin
            r_last_owner <= REQ_HOST;
        end
    end

    assign gnt0    = (r_state == ST_OWN0);
    assign gnt1    = (r_state == ST_OWN1);
    assign w_fire0 = gnt0 && req0;
    assign w_fire1 = gnt1 && req1;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_fire0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (w_fire1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // The tag is captured at issue time, so a read in the last cycle of a
    // burst returns to its issuer even though ownership has moved on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= REQ_FETCH;
        end else begin
            r_rd_pend <= mem_en && !mem_we;
            if (mem_en && !mem_we) begin
                r_rd_tag <= w_fire1 ? REQ_HOST : REQ_FETCH;
            end
        end
    end

    assign rvalid0 = r_rd_pend && (r_rd_tag == REQ_FETCH);
    assign rvalid1 = r_rd_pend && (r_rd_tag == REQ_HOST);
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a transaction-level ownership model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mem_port_arbiter;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              t_req0, t_req1, t_we0, t_we1;
    logic [ADDR_W-1:0] t_addr0, t_addr1;
    logic [DATA_W-1:0] t_wdata0, t_wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (t_req0),
        .addr0     (t_addr0),
        .wdata0    (t_wdata0),
        .we0       (t_we0),
        .req1      (t_req1),
        .addr1     (t_addr1),
        .wdata1    (t_wdata1),
        .we1       (t_we1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return DATA_W'(a * 37 + 16'h5A00);
    endfunction

    // RAM attached to the arbiter; refilled with a known pattern while in reset.
    logic [DATA_W-1:0] ram [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: who owns the port, how many accesses in this tenure,
    // who owned it last, and the read expected back next cycle.
    int                owner;
    int                acc;
    int                last_own;
    bit                pend;
    int                ptag;
    logic [DATA_W-1:0] pdata;
    logic [DATA_W-1:0] ref_mem [256];

    task automatic model_reset();
        owner    = -1;
        acc      = 0;
        last_own = 1;
        pend     = 1'b0;
        ptag     = 0;
        pdata    = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    endtask

    function automatic bit rq(input int i);
        return (i == 0) ? t_req0 : t_req1;
    endfunction

    task automatic step(input logic q0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0, input logic e0,
                        input logic q1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1, input logic e1);
        bit                f;
        logic              we_s;
        logic [ADDR_W-1:0] ad_s;
        logic [DATA_W-1:0] wd_s;
        int                nxt;
        t_req0 = q0; t_addr0 = a0; t_wdata0 = d0; t_we0 = e0;
        t_req1 = q1; t_addr1 = a1; t_wdata1 = d1; t_we1 = e1;
        @(negedge clk);
        f    = (owner >= 0) && rq(owner);
        we_s = (owner == 1) ? t_we1 : t_we0;
        ad_s = (owner == 1) ? t_addr1 : t_addr0;
        wd_s = (owner == 1) ? t_wdata1 : t_wdata0;
        chk("gnt0", 32'(gnt0), 32'(owner == 0));
        chk("gnt1", 32'(gnt1), 32'(owner == 1));
        chk("mem_en", 32'(mem_en), 32'(f));
        chk("mem_we", 32'(mem_we), 32'(f && we_s));
        chk("mem_addr", 32'(mem_addr), f ? 32'(ad_s) : 32'd0);
        chk("mem_wdata", 32'(mem_wdata), f ? 32'(wd_s) : 32'd0);
        chk("rvalid0", 32'(rvalid0), 32'(pend && ptag == 0));
        chk("rvalid1", 32'(rvalid1), 32'(pend && ptag == 1));
        if (pend) chk("rdata", 32'(rdata), 32'(pdata));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            pend = f && !we_s;
            if (f) begin
                ptag  = owner;
                pdata = ref_mem[ad_s];
                if (we_s) ref_mem[ad_s] = wd_s;
                acc++;
            end
            if (owner < 0) begin
                if (t_req0 && t_req1) nxt = (last_own == 1) ? 0 : 1;
                else if (t_req0)      nxt = 0;
                else if (t_req1)      nxt = 1;
                else                  nxt = -1;
            end else if (!rq(owner)) begin
                nxt = rq(1 - owner) ? 1 - owner : -1;
            end else if (rq(1 - owner) && acc >= MAX_BURST) begin
                nxt = 1 - owner;
            end else begin
                nxt = owner;
            end
            if (nxt != owner) begin
                acc = 0;
                if (nxt >= 0) last_own = nxt;
            end
            owner = nxt;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        t_req0 = 0; t_req1 = 0; t_we0 = 0; t_we1 = 0;
        t_addr0 = 0; t_addr1 = 0; t_wdata0 = 0; t_wdata1 = 0;
        model_reset();
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0, 0, 0);     // reset-state outputs while rst high
        rst = 1'b0;
        idle(2);

        // First tie after reset goes to requester 0.
        step(1, 8'h40, 0, 0, 1, 8'h50, 0, 0);
        step(1, 8'h40, 0, 0, 1, 8'h50, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Single requester burst of reads 0x00..0x05 (first cycle is the request).
        step(1, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, ADDR_W'(i), 0, 0, 0, 0, 0, 0);
        // Release with no other requester: IDLE next.
        idle(3);

        // Host write of 0xBEEF to 0x20; req0 rises as req1 drops.
        step(0, 0, 0, 0, 1, 8'h20, 16'hBEEF, 1);
        step(0, 0, 0, 0, 1, 8'h20, 16'hBEEF, 1);
        step(1, 8'h20, 0, 0, 0, 0, 0, 0);
        step(1, 8'h20, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Contention: fetch reads 0x10 repeatedly, host reads 0x30; alternating bursts.
        for (int i = 0; i < 20; i++) step(1, 8'h10, 0, 0, 1, 8'h30, 0, 0);
        // Forced switch coinciding with the owner dropping, then both drop.
        step(0, 8'h10, 0, 0, 1, 8'h31, 0, 0);
        step(0, 0, 0, 0, 1, 8'h32, 0, 0);
        idle(2);

        // Reset mid-burst with a read in flight.
        for (int i = 0; i < 3; i++) step(1, ADDR_W'(8'h60 + i), 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        model_reset();
        step(1, 8'h63, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(3);

        // Randomized traffic with sticky requests.
        for (int i = 0; i < 400; i++) begin
            logic q0, q1;
            q0 = ($urandom_range(0, 3) == 0) ? ~t_req0 : t_req0;
            q1 = ($urandom_range(0, 3) == 0) ? ~t_req1 : t_req1;
            step(q0, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), ($urandom_range(0, 2) == 0),
                 q1, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), ($urandom_range(0, 2) == 0));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing the single-ported program/data RAM between two requesters: the instruction-fetch path of the control unit (requester 0) and the host program loader/debug port (requester 1). It grants ownership one requester at a time through a small state machine and multiplexes address, write data and write enable onto the RAM. It caps consecutive accesses under contention with a burst limit and returns each read with a valid strobe tagged to the issuing requester.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width
- MAX_BURST, 4, max consecutive accesses by one owner while the other requests (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  requester i wants access; held high while it has accesses pending
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- we0 / we1  in  1  1 = write, 0 = read
- gnt0 / gnt1  out  1  requester i owns the RAM this cycle
- rvalid0 / rvalid1  out  1  read data for requester i valid on rdata
- rdata  out  DATA_W  shared read data (= mem_rdata)
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read strobe

## Operation
- States: IDLE, OWN0, OWN1. gnt_i = (state == OWN_i); gnt0 and gnt1 never both high.
- Access fires in any cycle with gnt_i && req_i: mem_en=1, mem_addr/mem_wdata/mem_we from requester i. Otherwise mem_en=0, mem_we=0 (address/data don't-care, drive 0).
- IDLE: only req0 → OWN0; only req1 → OWN1; both → requester ≠ last_owner; none → IDLE.
- OWN_i, req_i low: req_j high → OWN_j, else IDLE.
- OWN_i, req_i high: if req_j high and burst_cnt == MAX_BURST-1 (current access is the last allowed) → OWN_j; else stay, burst_cnt+1 (saturating at MAX_BURST-1 when req_j low).
- burst_cnt clears to 0 on every state change; last_owner updates to i on entry to OWN_i.
- Read tagging: a fired read registers rd_tag=i and rd_pend=1; next cycle rvalid_i=1. Tag is independent of ownership, so a read issued in the last cycle of a burst still returns to its issuer after the switch.
- Writes produce no rvalid.
- Reset values: state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, burst_cnt=0, last_owner=1 (requester 0 wins first tie).
- Reset mid-burst: ownership and any pending rvalid dropped immediately; no rvalid after reset deasserts.

## Timing
- req_i rises in IDLE at edge n → gnt_i high from edge n+1; first access in cycle n+1; read data/rvalid_i in cycle n+2.
- While owner: one access per cycle, back-to-back, no bubbles.
- Handover: zero idle cycles; last access of i in cycle k, gnt_j and first access of j in cycle k+1.
- req_i dropping in the same cycle as its forced switch: still OWN_j next (no IDLE bubble).
- Both drop simultaneously: IDLE next cycle.
- rvalid is a 1-cycle pulse per read; rdata meaningful only with an rvalid.

## Structure
- Shared package: state encoding (IDLE/OWN0/OWN1), requester IDs (REQ_FETCH=0, REQ_HOST=1), default MAX_BURST.
- One sub-module natural: arb_burst_counter (clear, increment, saturate, "last" flag at MAX_BURST-1). Mux and read tagging stay in the top.

## Test plan
- Reset: assert rst mid-burst with read in flight → all outputs 0 next cycle, no rvalid after release; first tie goes to req0.
- Single requester: req0 reads addr 0x00..0x05 → gnt0 from next cycle, six accesses back-to-back, rvalid0 each following cycle with matching data.
- Contention, MAX_BURST=4: req0 and req1 held high → grant pattern 4×OWN0, 4×OWN1, repeating; no idle cycles.
- Handover read tag: req0 last-burst read of addr 0x10 then switch → rvalid0 (not rvalid1) with mem[0x10] in first OWN1 cycle.
- Writes: req1 writes 0xBEEF to 0x20, then req0 reads 0x20 → rvalid0 with 0xBEEF; no rvalid for the write.
- Release: req0 drops while req1 idle → IDLE next cycle, mem_en=0; req1 rises same cycle req0 drops → OWN1 next cycle.
